// File: rtl/srff_stim_gen.sv
// srff_stim_gen: built-in self-test driver and checker for an SR flip-flop.
//
// A run walks the flop through SET, RESET and HOLD phases. Each phase lasts
// HOLD_CYCLES clocks, and the whole round repeats NUM_LOOPS times. On the last
// cycle of every phase the flop's q/qbar are compared against the value that
// phase should have produced. Mismatches are counted in a saturating counter.
//
// Parameters:
//   HOLD_CYCLES  clocks per phase (>= 2)
//   NUM_LOOPS    SET/RESET/HOLD rounds per run (>= 1)
//   CNT_W        width of the error counter
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle run request; ignored while busy
//   q_in       q from the flop under test
//   qbar_in    qbar from the flop under test
//   s, r       registered set/reset drives to the flop (never both high)
//   busy       high for the duration of a run
//   done       one-cycle pulse after the final HOLD phase
//   pass       last completed run had no errors; cleared by start
//   err_count  mismatches in the current/last run, saturating
//   phase      0=IDLE, 1=SET, 2=RESET, 3=HOLD
module srff_stim_gen #(
  parameter int HOLD_CYCLES = 5,
  parameter int NUM_LOOPS   = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q_in,
  input  logic             qbar_in,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       phase
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int LW = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(NUM_LOOPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET   = 2'd1,
    ST_RESET = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [LW-1:0]   loop_cnt;
  logic            exp_q;
  logic            mismatch;
  logic [CNT_W-1:0] err_next;

  // Saturating increment of the error counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  // Only SET should leave q high; HOLD retains the RESET value of 0.
  assign exp_q    = (state == ST_SET);
  assign mismatch = (q_in != exp_q) || (qbar_in != ~q_in);
  assign err_next = sat_inc(err_count, mismatch);

  // The state register is the phase output, so it moves on the same edge as s/r.
  assign phase = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      s         <= 1'b0;
      r         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      hold_cnt  <= '0;
      loop_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          s <= 1'b0;
          r <= 1'b0;
          if (start) begin
            state     <= ST_SET;
            s         <= 1'b1;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            hold_cnt  <= '0;
            loop_cnt  <= '0;
          end
        end
        default: begin
          if (hold_cnt == HOLD_LAST) begin
            // Check point: q has had HOLD_CYCLES-1 cycles to settle.
            err_count <= err_next;
            hold_cnt  <= '0;
            case (state)
              ST_SET: begin
                state <= ST_RESET;
                s     <= 1'b0;
                r     <= 1'b1;
              end
              ST_RESET: begin
                state <= ST_HOLD;
                s     <= 1'b0;
                r     <= 1'b0;
              end
              default: begin
                s <= 1'b0;
                r <= 1'b0;
                if (loop_cnt == LOOP_LAST) begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass     <= (err_next == '0);
                  loop_cnt <= '0;
                end else begin
                  state    <= ST_SET;
                  s        <= 1'b1;
                  loop_cnt <= loop_cnt + LW'(1);
                end
              end
            endcase
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/srff_stim_gen.md
Name: srff_stim_gen

Overview:
- Synthesizable stimulus driver and response checker for an SR flip-flop (built-in self-test).
- Drives the flop's s/r inputs through programmed phases: SET, RESET, HOLD, repeated a set number of times.
- Samples the flop's q/qbar back and flags mismatches.
- Sits beside the srff in the top level, replacing the hand-written bench stimulus on hardware.

Parameters:
- HOLD_CYCLES, 5, clocks spent in each phase; must be >= 2.
- NUM_LOOPS, 1, number of SET/RESET/HOLD rounds per run; must be >= 1.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; ignored while busy.
- q_in  input  1  q from the flop under test.
- qbar_in  input  1  qbar from the flop under test.
- s  output  1  set drive to the flop (registered).
- r  output  1  reset drive to the flop (registered).
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  high when the last completed run had zero errors; held until the next start.
- err_count  output  CNT_W  mismatches in the current/last run; saturates at all-ones.
- phase  output  2  current phase: 0=IDLE, 1=SET, 2=RESET, 3=HOLD.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-run): state IDLE; s=0, r=0, busy=0, done=0, pass=0, err_count=0, phase=0; hold and loop counters cleared.
- States and outputs:
  - IDLE: s=0, r=0.
  - SET: s=1, r=0.
  - RESET: s=0, r=1.
  - HOLD: s=0, r=0.
- s and r are never both 1 in any cycle, including during transitions and reset.
- IDLE -> SET: on the edge where start=1.
  - That edge also sets busy=1 and clears err_count and pass.
  - s=1 is visible in the first cycle after that edge.
- Phase advance:
  - Each phase lasts exactly HOLD_CYCLES clocks, counted by hold_cnt from 0 to HOLD_CYCLES-1.
  - SET -> RESET -> HOLD. From HOLD: loop_cnt increments.
  - If loop_cnt < NUM_LOOPS-1, go to SET; otherwise go to IDLE.
- Run length: total busy cycles = 3*HOLD_CYCLES*NUM_LOOPS.
- Check point: the last cycle of each phase (hold_cnt == HOLD_CYCLES-1).
  - The flop has one cycle of latency, so q is stable from the second cycle of a phase.
  - Expected q: SET=1, RESET=0, HOLD=0 (retains the RESET value).
  - Mismatch = (q_in != expected) OR (qbar_in != ~q_in).
  - Each mismatch increments err_count by 1, saturating at 2^CNT_W-1.
- Completion: on the edge leaving the final HOLD phase:
  - done=1 for exactly one cycle, busy=0.
  - pass = (err_count == 0 after that phase's check is included).
- start while busy is ignored; no queuing and no restart.
- start in the same cycle done is high: accepted. The new run begins next cycle, err_count clears, pass clears.
- phase output equals the state encoding and updates on the same edge as s/r.

Test Plan:
- Good flop, HOLD_CYCLES=5, NUM_LOOPS=1, start at cycle 2 -> s=1 for cycles 3-7, r=1 for 8-12, s=r=0 for 13-17; done pulses once at cycle 18; pass=1, err_count=0.
- q_in tied 0, qbar_in tied 1 -> SET check fails only; after done err_count=1, pass=0.
- qbar_in tied equal to q_in on a good flop -> all 3 checks fail; err_count=3, pass=0.
- NUM_LOOPS=3, good flop -> phase sequence 1,2,3 repeated 3 times; busy high for 45 cycles; done once; pass=1.
- Pulse start during cycle 10 of a run -> no effect; the run completes on the original schedule.
- rst asserted mid-RESET phase -> next cycle s=0, r=0, phase=0, busy=0, err_count=0. A following start runs a full clean sequence with pass=1.
- Every cycle of every scenario: assert !(s && r).
